rt_axis_frontend: RTL and testbench
===================================

# rt_axis_frontend

Parametrised AXI-Stream front end of the raytracer coprocessor. Accepts a fixed-length scene/camera configuration packet on the slave stream and latches it for the renderer. It then starts the renderer and forwards its pixel stream to the master stream, framing it with `tlast` per frame or per line. It replaces the fixed 27-word / 32×32 / whole-frame-`tlast` front end and adds packet-length checking, selectable framing and full-throughput output buffering.

## Interface
Parameters:
- `DATA_W`, 32, stream and pixel word width
- `CFG_WORDS`, 27, configuration words per packet (≥2)
- `IMG_W`, 32, pixels per line (≥1)
- `IMG_H`, 32, lines per frame (≥1)
- `TLAST_PER_LINE`, 0, 0: `tlast` on last pixel of frame; 1: `tlast` on last pixel of each line

Ports:
- `aclk`  in  1  single clock; all logic on rising edge
- `areset`  in  1  asynchronous, active-high reset
- `s_axis_tvalid`  in  1  config beat valid
- `s_axis_tready`  out  1  front end accepts config beat
- `s_axis_tdata`  in  DATA_W  config word
- `s_axis_tlast`  in  1  last config beat
- `m_axis_tvalid`  out  1  pixel beat valid
- `m_axis_tready`  in  1  downstream accepts pixel
- `m_axis_tdata`  out  DATA_W  pixel word
- `m_axis_tlast`  out  1  end of line/frame per `TLAST_PER_LINE`
- `cfg_data`  out  CFG_WORDS*DATA_W  latched config; word i at bits [i*DATA_W +: DATA_W]
- `cfg_valid`  out  1  `cfg_data` holds a complete, checked packet
- `render_start`  out  1  one-cycle start pulse to renderer
- `pix_valid`  in  1  renderer pixel valid
- `pix_ready`  out  1  front end accepts pixel
- `pix_data`  in  DATA_W  renderer pixel
- `busy`  out  1  frame in progress (START through FLUSH)
- `cfg_err`  out  1  one-cycle pulse on a malformed config packet

## Operation
- FSM states:
  - CFG_RX
    - `s_axis_tready`=1.
    - Each accepted beat is written to word `cfg_idx`; `cfg_idx` then increments.
    - Beat with `tlast` and `cfg_idx==CFG_WORDS-1`: go to START; `cfg_valid`←1.
    - Beat with `tlast` and `cfg_idx<CFG_WORDS-1` (short packet): pulse `cfg_err`, set `cfg_idx`←0, `cfg_valid`←0, stay in CFG_RX.
    - Beat without `tlast` at `cfg_idx==CFG_WORDS-1` (long packet): go to DRAIN; `cfg_valid`←0.
  - DRAIN
    - `s_axis_tready`=1; beats are discarded.
    - The beat carrying `tlast` pulses `cfg_err` and returns the FSM to CFG_RX with `cfg_idx`=0.
  - START
    - Lasts one cycle; `render_start`=1.
    - `x`=0, `y`=0; next state is STREAM.
  - STREAM
    - `pix_ready` equals "skid buffer not full".
    - Each accepted pixel is pushed with `last = (x==IMG_W-1) && (TLAST_PER_LINE || y==IMG_H-1)`.
    - `x` wraps to 0 at IMG_W-1, and `y` increments on each wrap.
    - Accepting pixel (IMG_W-1, IMG_H-1) moves the FSM to FLUSH.
  - FLUSH
    - `pix_ready`=0; the FSM waits until the skid buffer is empty.
    - It then moves to CFG_RX with `cfg_idx`=0.
    - `cfg_valid` stays 1 until the first beat of the next packet is accepted.
- `s_axis_tready`=0 and `pix_ready`=0 outside the states listed above.
- Renderer pixels arriving in CFG_RX or DRAIN are not accepted.
- Counter widths:
  - `cfg_idx`: $clog2(CFG_WORDS).
  - `x`: $clog2(IMG_W), minimum 1.
  - `y`: $clog2(IMG_H), minimum 1.
  - All counter compares are exact; no counter overflow is possible.
- `busy`=1 in START, STREAM and FLUSH.

## Timing
- Reset (async assert, released synchronously by `aclk`):
  - State is CFG_RX and all counters are 0.
  - Every output is 0, including `s_axis_tready`, `cfg_data`, `cfg_valid` and `m_axis_*`.
  - `s_axis_tready` is registered and rises on the first edge after `areset` falls.
- Reset mid-frame: the partial frame is abandoned and the skid buffer is cleared without emitting `tlast`.
- The last config beat is accepted at edge N. `render_start`=1 in cycle N+1, and `pix_ready` can be 1 from cycle N+2.
- A pixel accepted at edge N appears on `m_axis` in cycle N+1, giving a latency of 1.
- Throughput is one pixel per cycle while `m_axis_tready`=1.
- `m_axis_tdata` and `m_axis_tlast` hold stable while `tvalid && !tready`.
- `m_axis_tvalid` never drops without a handshake.
- The skid buffer has 2 entries. `pix_ready` depends on registered state only, with no combinational path from `m_axis_tready`.

## Structure
- Package `rt_axis_pkg` holds:
  - the `state_e` enum (CFG_RX, DRAIN, START, STREAM, FLUSH);
  - the `pix_beat_t` struct {data, last}.
- Sub-module `axis_skid_buffer`:
  - parameter `T` (payload type);
  - 2-entry, registered valid/ready in both directions;
  - instanced once on the pixel path.

## Test plan
- 27 config beats with `tlast` on beat 27, `m_axis_tready`=1, renderer sends pixels 0..1023 → `cfg_data` word i = sent word i, one `render_start` pulse, 1024 beats out in order, `tlast` only on beat 1023, `busy` falls after it.
- `TLAST_PER_LINE`=1, IMG_W=4, IMG_H=3 → `tlast` on pixels 3, 7 and 11 only.
- Short packet (`tlast` on beat 5) → `cfg_err` pulse, no `render_start`, `cfg_valid`=0; a following valid 27-word packet starts a frame normally.
- Long packet (30 beats, `tlast` on beat 30) → beats 28–30 dropped, one `cfg_err` pulse when beat 30 is accepted, no `render_start`.
- Random `m_axis_tready` and `pix_valid` (50%) → output sequence identical to input, no data change while stalled, no lost or duplicated pixels.
- `areset` asserted at pixel 500 → all outputs 0 immediately; after release, `s_axis_tready`=1 and a new full frame completes correctly.

Source files
------------

// File: rtl/rt_axis_frontend_pkg.sv
// rt_axis_frontend_pkg: shared types for the raytracer AXI-Stream front end
//   state_e    - front-end FSM states
//   pix_beat_t - default pixel beat payload {data, last}
package rt_axis_pkg;

    localparam int PIX_W = 32;

    typedef enum logic [2:0] {
        CFG_RX,
        DRAIN,
        START,
        STREAM,
        FLUSH
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             last;
    } pix_beat_t;

endpackage

// File: rtl/rt_axis_frontend_if.sv
// axis_if: AXI-Stream bundle
//   tvalid/tdata/tlast driven by master, tready driven by slave
interface axis_if #(
    parameter int W = 32
);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master(output tvalid, output tdata, output tlast, input tready);
    modport slave(input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rt_axis_frontend_skid.sv
// axis_skid_buffer: 2-entry buffer with registered ready and valid
//   aclk/areset        clock, async active-high reset
//   in_valid/in_ready  upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload
module axis_skid_buffer
    import rt_axis_pkg::*;
#(
    parameter type T = pix_beat_t
) (
    input  logic aclk,
    input  logic areset,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    T           mem [2];
    logic       wr;
    logic       rd;
    logic [1:0] cnt;
    logic       push;
    logic       pop;

    // Both handshake outputs come straight from the occupancy register.
    assign in_ready  = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign out_data  = mem[rd];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr] <= in_data;
                wr      <= ~wr;
            end
            if (pop) rd <= ~rd;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/rt_axis_frontend.sv
// rt_axis_frontend: config packet receiver and pixel stream framer
//   aclk/areset          clock, async active-high reset
//   s_axis               config packet stream in
//   m_axis               framed pixel stream out
//   cfg_data/cfg_valid   latched, length-checked configuration
//   render_start         one-cycle renderer start pulse
//   pix_valid/ready/data renderer pixel handshake
//   busy, cfg_err        frame in progress, malformed packet pulse
module rt_axis_frontend
    import rt_axis_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CFG_WORDS      = 27,
    parameter int IMG_W          = 32,
    parameter int IMG_H          = 32,
    parameter int TLAST_PER_LINE = 0
) (
    input  logic                        aclk,
    input  logic                        areset,
    axis_if.slave                       s_axis,
    axis_if.master                      m_axis,
    output logic [CFG_WORDS*DATA_W-1:0] cfg_data,
    output logic                        cfg_valid,
    output logic                        render_start,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [DATA_W-1:0]           pix_data,
    output logic                        busy,
    output logic                        cfg_err
);
    localparam int CW = $clog2(CFG_WORDS);
    localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    state_e        state;
    state_e        nxt;
    logic [CW-1:0] cfg_idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          s_rdy;
    logic          s_acc;
    logic          idx_end;
    logic          p_acc;
    logic          x_end;
    logic          y_end;
    logic          sk_ready;
    logic          sk_valid;
    beat_t         sk_in;
    beat_t         sk_out;

    assign s_axis.tready = s_rdy;
    assign s_acc         = s_axis.tvalid && s_rdy;
    assign idx_end       = cfg_idx == CW'(CFG_WORDS - 1);
    assign x_end         = x == XW'(IMG_W - 1);
    assign y_end         = y == YW'(IMG_H - 1);
    assign pix_ready     = state == STREAM && sk_ready;
    assign p_acc         = pix_valid && pix_ready;
    assign render_start  = state == START;
    assign busy          = state inside {START, STREAM, FLUSH};
    assign sk_in         = '{data: pix_data, last: x_end && (TLAST_PER_LINE != 0 || y_end)};
    assign m_axis.tvalid = sk_valid;
    assign m_axis.tdata  = sk_out.data;
    assign m_axis.tlast  = sk_out.last;

    always_comb begin
        nxt     = state;
        cfg_err = 1'b0;
        case (state)
            CFG_RX: begin
                if (s_acc && idx_end) nxt = s_axis.tlast ? START : DRAIN;
                cfg_err = s_acc && s_axis.tlast && !idx_end;
            end
            DRAIN: begin
                if (s_acc && s_axis.tlast) nxt = CFG_RX;
                cfg_err = s_acc && s_axis.tlast;
            end
            START:   nxt = STREAM;
            STREAM:  if (p_acc && x_end && y_end) nxt = FLUSH;
            FLUSH:   if (!sk_valid) nxt = CFG_RX;
            default: nxt = CFG_RX;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= CFG_RX;
            s_rdy     <= 1'b0;
            cfg_idx   <= '0;
            x         <= '0;
            y         <= '0;
            cfg_data  <= '0;
            cfg_valid <= 1'b0;
        end else begin
            state <= nxt;
            // Ready is registered from the next state so it never glitches with tvalid.
            s_rdy <= nxt == CFG_RX || nxt == DRAIN;
            if (state == CFG_RX && s_acc) begin
                cfg_data[cfg_idx*DATA_W +: DATA_W] <= s_axis.tdata;
                cfg_idx   <= s_axis.tlast || idx_end ? '0 : cfg_idx + 1'b1;
                cfg_valid <= s_axis.tlast && idx_end;
            end
            if (state == START) begin
                x <= '0;
                y <= '0;
            end else if (p_acc) begin
                x <= x_end ? '0 : x + 1'b1;
                if (x_end) y <= y_end ? '0 : y + 1'b1;
            end
        end
    end

    axis_skid_buffer #(.T(beat_t)) u_skid (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (p_acc),
        .in_ready  (sk_ready),
        .in_data   (sk_in),
        .out_valid (sk_valid),
        .out_ready (m_axis.tready),
        .out_data  (sk_out)
    );
endmodule

// File: tb/tb_rt_axis_frontend.sv
// tb_rt_axis_frontend: self-checking bench with a queue-based frame model
module tb_rt_axis_frontend;
    localparam int DW = 32;
    localparam int CW = 27;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int NP = W * H;

    logic aclk = 1'b0;
    logic areset = 1'b0;
    always #5 aclk = ~aclk;

    axis_if #(.W(DW)) s ();
    axis_if #(.W(DW)) m ();
    axis_if #(.W(DW)) s1 ();
    axis_if #(.W(DW)) m1 ();

    logic [CW*DW-1:0] cfg_data;
    logic [2*DW-1:0]  cfg1;
    logic             cfg_valid, render_start, pix_valid, pix_ready, busy, cfg_err;
    logic [DW-1:0]    pix_data;
    logic             cv1, rs1, pv1, pr1, b1, ce1;
    logic [DW-1:0]    pd1;

    rt_axis_frontend #(.DATA_W(DW), .CFG_WORDS(CW), .IMG_W(W), .IMG_H(H), .TLAST_PER_LINE(0)) dut (
        .aclk(aclk), .areset(areset), .s_axis(s), .m_axis(m),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .render_start(render_start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .busy(busy), .cfg_err(cfg_err)
    );

    rt_axis_frontend #(.DATA_W(DW), .CFG_WORDS(2), .IMG_W(4), .IMG_H(3), .TLAST_PER_LINE(1)) dut1 (
        .aclk(aclk), .areset(areset), .s_axis(s1), .m_axis(m1),
        .cfg_data(cfg1), .cfg_valid(cv1), .render_start(rs1),
        .pix_valid(pv1), .pix_ready(pr1), .pix_data(pd1),
        .busy(b1), .cfg_err(ce1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted pixel is expected out in order; its tlast follows
    // from its position within the frame counted since render_start.
    logic [DW:0]   q[$];
    logic [DW:0]   exp_beat;
    logic [DW:0]   held;
    logic [DW-1:0] last_data;
    int            fpix = 0, n_out = 0, n_last = 0, last_at = 0, n_start = 0, n_err = 0;
    int            k1 = 0, lasts1 = 0;
    bit            stall_q = 0;

    always @(negedge aclk) begin
        if (areset) begin
            q.delete();
            fpix    = 0;
            stall_q = 0;
        end else begin
            if (stall_q) chk("hold", {m.tvalid, m.tlast, m.tdata}, {1'b1, held});
            chk("ready_only_busy", pix_ready & ~busy, 0);
            if (render_start) begin
                n_start++;
                fpix = 0;
            end
            if (cfg_err) n_err++;
            if (pix_valid && pix_ready) begin
                q.push_back({fpix == NP - 1, pix_data});
                fpix++;
            end
            if (m.tvalid && m.tready) begin
                if (q.size() == 0) chk("spurious_beat", 1, 0);
                else begin
                    exp_beat = q.pop_front();
                    chk("beat", {m.tlast, m.tdata}, exp_beat);
                end
                n_out++;
                if (m.tlast) begin
                    n_last++;
                    last_at   = n_out;
                    last_data = m.tdata;
                end
            end
            stall_q = m.tvalid && !m.tready;
            held    = {m.tlast, m.tdata};
            if (m1.tvalid && m1.tready) begin
                chk("pl_data", m1.tdata, k1);
                chk("pl_last", m1.tlast, k1 % 4 == 3);
                if (m1.tlast) lasts1++;
                k1++;
            end
        end
    end

    int pv_pct = 100, mr_pct = 100;
    bit pen = 0;
    bit phs, phs1;

    initial begin
        pix_valid = 0;
        pix_data  = 0;
        m.tready  = 0;
        pd1       = 0;
        forever begin
            @(negedge aclk);
            phs  = pix_valid && pix_ready && !areset;
            phs1 = pv1 && pr1 && !areset;
            @(posedge aclk);
            #1;
            if (phs) pix_data++;
            if (phs1) pd1++;
            pix_valid = pen && ($urandom_range(99) < pv_pct);
            m.tready  = $urandom_range(99) < mr_pct;
        end
    end

    task automatic send_cfg(input int n, input int last_at_beat, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            s.tvalid = 1;
            s.tdata  = base + i;
            s.tlast  = (i == last_at_beat - 1);
            t = 0;
            do begin
                @(negedge aclk);
                t++;
            end while (!s.tready && t < 200);
            if (!s.tready) chk("cfg_timeout", 0, 1);
            @(posedge aclk);
            #1;
        end
        s.tvalid = 0;
        s.tlast  = 0;
    endtask

    task automatic check_cfg(input string nm, input int n, input logic [DW-1:0] base);
        int bad = 0;
        for (int i = 0; i < n; i++) if (cfg_data[i*DW +: DW] !== base + i) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic wait_out(input int target);
        int t = 0;
        while (n_out < target && t < 20000) begin
            @(posedge aclk);
            t++;
        end
        #1;
        if (n_out < target) chk("out_timeout", n_out, target);
    endtask

    int o0, l0, st0, e0;

    initial begin
        s.tvalid = 0; s.tdata = 0; s.tlast = 0;
        s1.tvalid = 0; s1.tdata = 0; s1.tlast = 0;
        pv1 = 0; m1.tready = 1;
        #2 areset = 1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_s_tready", s.tready, 0);
        chk("rst_m_tvalid", m.tvalid, 0);
        chk("rst_m_payload", {m.tlast, m.tdata}, 0);
        chk("rst_cfg", {|cfg_data, cfg_valid}, 0);
        chk("rst_misc", {render_start, busy, pix_ready, cfg_err}, 0);
        areset = 0;
        chk("tready_before_edge", s.tready, 0);
        @(posedge aclk);
        #1;
        chk("tready_after_edge", s.tready, 1);

        // per-line framing on the 4x3 instance
        for (int k = 0; k < 2; k++) begin
            int t = 0;
            s1.tvalid = 1; s1.tdata = 7 + k; s1.tlast = (k == 1);
            do begin @(negedge aclk); t++; end while (!s1.tready && t < 50);
            @(posedge aclk);
            #1;
        end
        s1.tvalid = 0; s1.tlast = 0;
        chk("pl_cfg", cfg1, {32'd8, 32'd7});
        pv1 = 1;
        repeat (40) @(posedge aclk);
        #1;
        pv1 = 0;
        chk("pl_count", k1, 12);
        chk("pl_lasts", lasts1, 3);
        chk("pl_idle", b1, 0);

        // full frame, no stalls
        send_cfg(CW, CW, 32'h100);
        chk("start_pulse", {render_start, busy, cfg_valid}, 3'b111);
        check_cfg("cfg_words", CW, 32'h100);
        pix_data = 0;
        pen = 1;
        wait_out(NP);
        pen = 0;
        repeat (4) @(posedge aclk);
        #1;
        chk("f1_out", n_out, NP);
        chk("f1_lasts", n_last, 1);
        chk("f1_last_at", last_at, NP);
        chk("f1_last_data", last_data, NP - 1);
        chk("f1_starts", n_start, 1);
        chk("f1_idle", {busy, cfg_valid, s.tready}, 3'b011);

        // short packet
        st0 = n_start; e0 = n_err;
        send_cfg(5, 5, 32'h200);
        repeat (3) @(posedge aclk);
        #1;
        chk("short_err", n_err - e0, 1);
        chk("short_nostart", n_start - st0, 0);
        chk("short_state", {cfg_valid, busy}, 0);

        // valid packet after short one, random stalls on both sides
        o0 = n_out; l0 = n_last;
        pv_pct = 50; mr_pct = 50;
        send_cfg(CW, CW, 32'h300);
        check_cfg("cfg_after_short", CW, 32'h300);
        pix_data = 0;
        pen = 1;
        wait_out(o0 + NP);
        pen = 0;
        mr_pct = 100;
        repeat (6) @(posedge aclk);
        #1;
        chk("rnd_out", n_out - o0, NP);
        chk("rnd_lasts", n_last - l0, 1);
        chk("rnd_last_data", last_data, NP - 1);
        chk("rnd_starts", n_start - st0, 1);
        chk("rnd_idle", busy, 0);

        // long packet
        st0 = n_start; e0 = n_err;
        send_cfg(30, 30, 32'h400);
        repeat (3) @(posedge aclk);
        #1;
        chk("long_err", n_err - e0, 1);
        chk("long_nostart", n_start - st0, 0);
        chk("long_valid", cfg_valid, 0);
        check_cfg("long_words", CW, 32'h400);

        // reset mid-frame
        pv_pct = 100;
        o0 = n_out;
        send_cfg(CW, CW, 32'h500);
        pix_data = 0;
        pen = 1;
        wait_out(o0 + 500);
        pen = 0;
        l0 = n_last;
        areset = 1;
        #1;
        chk("mid_rst_m", {m.tvalid, m.tlast, m.tdata}, 0);
        chk("mid_rst_misc", {s.tready, busy, cfg_valid, pix_ready, render_start, |cfg_data}, 0);
        @(posedge aclk);
        #1;
        areset = 0;
        @(posedge aclk);
        #1;
        chk("mid_rst_tready", s.tready, 1);
        chk("mid_rst_nolast", n_last, l0);
        o0 = n_out; st0 = n_start;
        send_cfg(CW, CW, 32'h600);
        check_cfg("cfg_after_rst", CW, 32'h600);
        pix_data = 0;
        pen = 1;
        wait_out(o0 + NP);
        pen = 0;
        repeat (4) @(posedge aclk);
        #1;
        chk("rst_frame_out", n_out - o0, NP);
        chk("rst_frame_lasts", n_last - l0, 1);
        chk("rst_frame_last_data", last_data, NP - 1);
        chk("rst_frame_starts", n_start - st0, 1);
        chk("rst_frame_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
